// File: rtl/alu_muldiv.sv
// alu_muldiv: RV32I execute-stage ALU with an iterative radix-2 RV32M multiply/divide unit.
// Define ALU_MULDIV_EN to build MUL*/DIV*/REM*; without it those codes return 0 after one cycle.
module alu_muldiv #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  input  logic [OPW-1:0]  aluop,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] opr_res,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);

  localparam logic [OPW-1:0] op_add  = OPW'(0);
  localparam logic [OPW-1:0] op_sub  = OPW'(1);
  localparam logic [OPW-1:0] op_sll  = OPW'(2);
  localparam logic [OPW-1:0] op_slt  = OPW'(3);
  localparam logic [OPW-1:0] op_sltu = OPW'(4);
  localparam logic [OPW-1:0] op_xor  = OPW'(5);
  localparam logic [OPW-1:0] op_srl  = OPW'(6);
  localparam logic [OPW-1:0] op_sra  = OPW'(7);
  localparam logic [OPW-1:0] op_or   = OPW'(8);
  localparam logic [OPW-1:0] op_and  = OPW'(9);

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] res_reg, res_next;

  assign shamt = opr_b[SW-1:0];

  always_comb begin
    base_res = '0;
    case (aluop)
      op_add:  base_res = opr_a + opr_b;
      op_sub:  base_res = opr_a - opr_b;
      op_sll:  base_res = opr_a << shamt;
      op_slt:  base_res = XLEN'($signed(opr_a) < $signed(opr_b));
      op_sltu: base_res = XLEN'(opr_a < opr_b);
      op_xor:  base_res = opr_a ^ opr_b;
      op_srl:  base_res = opr_a >> shamt;
      op_sra:  base_res = $unsigned($signed(opr_a) >>> shamt);
      op_or:   base_res = opr_a | opr_b;
      op_and:  base_res = opr_a & opr_b;
      default: base_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [OPW-1:0] op_mul    = OPW'(10);
  localparam logic [OPW-1:0] op_mulh   = OPW'(11);
  localparam logic [OPW-1:0] op_mulhsu = OPW'(12);
  localparam logic [OPW-1:0] op_mulhu  = OPW'(13);
  localparam logic [OPW-1:0] op_div    = OPW'(14);
  localparam logic [OPW-1:0] op_divu   = OPW'(15);
  localparam logic [OPW-1:0] op_rem    = OPW'(16);
  localparam logic [OPW-1:0] op_remu   = OPW'(17);

  typedef enum logic [1:0] {s_idle, s_mul, s_div, s_done} state_t;

  logic [SW-1:0]     cnt_reg, cnt_next;
  logic [XLEN-1:0]   acc_reg, acc_next;   // product high half / partial remainder
  logic [XLEN-1:0]   lo_reg, lo_next;     // multiplier bits / dividend-then-quotient bits
  logic [XLEN-1:0]   mag_reg, mag_next;   // multiplicand or divisor magnitude
  logic              neg_reg, neg_next;
  logic              hi_reg, hi_next;     // select high half (mul) or remainder (div)
  logic              a_sgn, b_sgn, is_mul, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, quo_fin, rem_fin, rem_step;
  logic [XLEN:0]     mul_sum, rem_shift, div_trial;
  logic [2*XLEN-1:0] prod, prod_fin;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (aluop)
      op_mulh, op_div, op_rem: begin
        a_sgn = opr_a[XLEN-1];
        b_sgn = opr_b[XLEN-1];
      end
      op_mulhsu: a_sgn = opr_a[XLEN-1];
      default: ;
    endcase
    a_mag = a_sgn ? -opr_a : opr_a;
    b_mag = b_sgn ? -opr_b : opr_b;
  end

  assign is_mul   = aluop inside {op_mul, op_mulh, op_mulhsu, op_mulhu};
  assign is_div   = aluop inside {op_div, op_divu, op_rem, op_remu};
  assign div_zero = (opr_b == '0);
  assign div_ovf  = (aluop == op_div || aluop == op_rem) &&
                    (opr_a == {1'b1, {(XLEN-1){1'b0}}}) && (opr_b == '1);

  // Sign correction is folded into the final step so DONE sees the finished value.
  assign mul_sum   = {1'b0, acc_reg} + (lo_reg[0] ? {1'b0, mag_reg} : {(XLEN+1){1'b0}});
  assign prod      = {mul_sum[XLEN:1], mul_sum[0], lo_reg[XLEN-1:1]};
  assign prod_fin  = neg_reg ? -prod : prod;
  assign rem_shift = {acc_reg, lo_reg[XLEN-1]};
  assign div_trial = rem_shift - {1'b0, mag_reg};
  assign rem_step  = div_trial[XLEN] ? rem_shift[XLEN-1:0] : div_trial[XLEN-1:0];
  assign quo_fin   = {lo_reg[XLEN-2:0], ~div_trial[XLEN]};
  assign rem_fin   = rem_step;
`else
  typedef enum logic {s_idle, s_done} state_t;
`endif

  state_t state_reg, state_next;

  always_comb begin
    state_next = state_reg;
    res_next   = res_reg;
`ifdef ALU_MULDIV_EN
    cnt_next = cnt_reg;
    acc_next = acc_reg;
    lo_next  = lo_reg;
    mag_next = mag_reg;
    neg_next = neg_reg;
    hi_next  = hi_reg;
`endif
    if (kill) begin
      state_next = s_idle;
    end else begin
      case (state_reg)
        s_idle: if (in_valid) begin
          state_next = s_done;
          res_next   = base_res;
`ifdef ALU_MULDIV_EN
          if (is_mul) begin
            state_next = s_mul;
            cnt_next   = '0;
            acc_next   = '0;
            mag_next   = a_mag;
            lo_next    = b_mag;
            neg_next   = a_sgn ^ b_sgn;
            hi_next    = (aluop != op_mul);
          end else if (is_div) begin
            if (div_zero) begin
              res_next = (aluop == op_div || aluop == op_divu) ? '1 : opr_a;
            end else if (div_ovf) begin
              res_next = (aluop == op_div) ? opr_a : '0;
            end else begin
              state_next = s_div;
              cnt_next   = '0;
              acc_next   = '0;
              mag_next   = b_mag;
              lo_next    = a_mag;
              neg_next   = (aluop == op_div) ? (a_sgn ^ b_sgn) : a_sgn;
              hi_next    = (aluop == op_rem || aluop == op_remu);
            end
          end
`endif
        end
`ifdef ALU_MULDIV_EN
        s_mul: begin
          acc_next = mul_sum[XLEN:1];
          lo_next  = {mul_sum[0], lo_reg[XLEN-1:1]};
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == SW'(XLEN-1)) begin
            state_next = s_done;
            res_next   = hi_reg ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];
          end
        end
        s_div: begin
          acc_next = rem_step;
          lo_next  = quo_fin;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == SW'(XLEN-1)) begin
            state_next = s_done;
            if (hi_reg) res_next = neg_reg ? -rem_fin : rem_fin;
            else        res_next = neg_reg ? -quo_fin : quo_fin;
          end
        end
`endif
        s_done: if (out_ready) state_next = s_idle;
        default: state_next = s_idle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= s_idle;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      res_reg   <= res_next;
    end
  end

`ifdef ALU_MULDIV_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      acc_reg <= '0;
      lo_reg  <= '0;
      mag_reg <= '0;
      neg_reg <= 1'b0;
      hi_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      acc_reg <= acc_next;
      lo_reg  <= lo_next;
      mag_reg <= mag_next;
      neg_reg <= neg_next;
      hi_reg  <= hi_next;
    end
  end

  assign busy = (state_reg == s_mul) || (state_reg == s_div);
`else
  assign busy = 1'b0;
`endif

  assign in_ready  = (state_reg == s_idle);
  assign out_valid = (state_reg == s_done);
  assign opr_res   = res_reg;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv; MUL/DIV expectations follow the ALU_MULDIV_EN build setting.
module tb_alu_muldiv;
  localparam int XLEN = 32;
  localparam int OPW  = 5;

  localparam logic [4:0] op_add = 5'd0, op_sub = 5'd1, op_sll = 5'd2, op_slt = 5'd3,
                         op_sltu = 5'd4, op_xor = 5'd5, op_srl = 5'd6, op_sra = 5'd7,
                         op_or = 5'd8, op_and = 5'd9, op_mul = 5'd10, op_mulh = 5'd11,
                         op_mulhsu = 5'd12, op_mulhu = 5'd13, op_div = 5'd14, op_divu = 5'd15,
                         op_rem = 5'd16, op_remu = 5'd17;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, kill, out_valid, out_ready, busy;
  logic [XLEN-1:0] opr_a, opr_b, opr_res;
  logic [OPW-1:0]  aluop;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opr_a(opr_a), .opr_b(opr_b), .aluop(aluop), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .opr_res(opr_res), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Issue one op with out_ready=1, measure latency from the accept edge, check result and handshakes.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    int   busy_cyc;
    logic rdy_seen;
    aluop = op; opr_a = a; opr_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1; busy_cyc = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cyc++;
      if (in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, opr_res, exp_res);
    chk({tag, " busy cycles"}, 32'(busy_cyc), 32'(exp_lat - 1));
    if (exp_lat > 1) chk({tag, " in_ready while busy"}, 32'(rdy_seen), 32'd0);
    tick();
    chk({tag, " back to idle"}, 32'({in_ready, out_valid}), 32'b10);
    $display("op %-10s a=%08h b=%08h res=%08h lat=%0d", tag, a, b, opr_res, lat);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
    opr_a = '0; opr_b = '0; aluop = '0;
    tick(); tick();
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset opr_res", opr_res, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("add", op_add, 32'd5, 32'd7, 32'd12, 1);
    run_op("sub", op_sub, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
    run_op("sra", op_sra, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    run_op("sltu", op_sltu, 32'd1, 32'hFFFF_FFFF, 32'd1, 1);
    run_op("slt", op_slt, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("sll", op_sll, 32'd1, 32'd31, 32'h8000_0000, 1);
    run_op("srl", op_srl, 32'h8000_0000, 32'd36, 32'h0800_0000, 1);
    run_op("xor", op_xor, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1);
    run_op("or", op_or, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1);
    run_op("and", op_and, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1);
    run_op("undef31", 5'd31, 32'd9, 32'd9, 32'd0, 1);

`ifdef ALU_MULDIV_EN
    run_op("mul", op_mul, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33);
    run_op("mulhu", op_mulhu, 32'hFFFF_FFFF, 32'd2, 32'd1, 33);
    run_op("mulh", op_mulh, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("mulhsu", op_mulhsu, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("mulh_min", op_mulh, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("div", op_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem", op_rem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("rem_negb", op_rem, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu", op_divu, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", op_remu, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_by0", op_divu, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", op_remu, 32'd7, 32'd0, 32'd7, 1);
    run_op("div_ovf", op_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", op_rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
`else
    run_op("mul_off", op_mul, 32'd3, 32'd4, 32'd0, 1);
    run_op("divu_off", op_divu, 32'd100, 32'd7, 32'd0, 1);
`endif

    // Backpressure: DONE holds while out_ready=0 and ignores a pending in_valid.
    out_ready = 1'b0;
    aluop = op_add; opr_a = 32'd1; opr_b = 32'd2; in_valid = 1'b1;
    tick();
    aluop = op_sub; opr_a = 32'd9; opr_b = 32'd4;
    chk("bp out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp hold res", opr_res, 32'd3);
      chk("bp hold handshake", 32'({out_valid, in_ready}), 32'b10);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp release idle", 32'({in_ready, out_valid}), 32'b10);
    tick();
    chk("bp nothing accepted", 32'(out_valid), 32'd0);
    chk("bp res kept", opr_res, 32'd3);
    $display("op backpressure res=%08h", opr_res);

    // kill while a result waits in DONE.
    out_ready = 1'b0;
    aluop = op_add; opr_a = 32'd10; opr_b = 32'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("kill done pre valid", 32'(out_valid), 32'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0; out_ready = 1'b1;
    chk("kill done handshake", 32'({in_ready, out_valid}), 32'b10);
    $display("op kill-in-done");

    // kill together with in_valid in IDLE: nothing accepted.
    aluop = op_add; opr_a = 32'd1; opr_b = 32'd1; in_valid = 1'b1; kill = 1'b1;
    tick();
    in_valid = 1'b0; kill = 1'b0;
    chk("kill ovr valid", 32'(out_valid), 32'd0);
    tick();
    chk("kill ovr valid late", 32'(out_valid), 32'd0);
    $display("op kill-with-in_valid");

`ifdef ALU_MULDIV_EN
    // kill at cycle 10 of a DIVU.
    aluop = op_divu; opr_a = 32'd100; opr_b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("kill div busy before", 32'(busy), 32'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill div handshake", 32'({in_ready, out_valid, busy}), 32'b100);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("kill div no result", 32'(seen), 32'd0);
    $display("op kill-mid-divu");

    // Reset mid-MUL after a nonzero result.
    run_op("add_pre_rst", op_add, 32'd5, 32'd7, 32'd12, 1);
    aluop = op_mul; opr_a = 32'hFFFF_FFFF; opr_b = 32'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst mid busy before", 32'(busy), 32'd1);
`else
    // Reset while a nonzero result waits in DONE.
    out_ready = 1'b0;
    aluop = op_add; opr_a = 32'd5; opr_b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst mid res before", opr_res, 32'd12);
`endif
    rst_n = 1'b0;
    tick();
    chk("rst mid in_ready", 32'(in_ready), 32'd1);
    chk("rst mid out_valid", 32'(out_valid), 32'd0);
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid opr_res", opr_res, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    $display("op reset-mid-op");

    run_op("add_after", op_add, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("sub_after", op_sub, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
